updown_counter_param: RTL and testbench



---
 rtl/counter_pkg.sv | 7 +
 rtl/counter_step.sv | 24 ++
 rtl/updown_counter_param.sv | 49 ++++
 tb/tb_updown_counter_param.sv | 104 ++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and direction constants for the up/down counter
package counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
endpackage

// File: rtl/counter_step.sv
// counter_step: combinational next-count and boundary-event logic (cur, direction, max_val, sat_mode -> next, boundary_event)
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             direction,
  input  logic [WIDTH-1:0] max_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next,
  output logic             boundary_event
);
  logic up_edge;
  logic dn_edge;
  always_comb begin
    up_edge        = cur >= max_val;
    dn_edge        = cur == '0;
    boundary_event = direction == DIR_UP ? up_edge : dn_edge;
    next           = direction == DIR_UP
                   ? (up_edge ? (sat_mode == MODE_SAT ? max_val : '0) : cur + 1'b1)
                   : (dn_edge ? (sat_mode == MODE_SAT ? '0 : max_val) : cur - 1'b1);
  end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with load, limit, wrap/saturate, tc pulse and sticky overflow
// ports: clk, rst (sync high), enable, direction, load, load_val, max_val, sat_mode, clr_ovf -> counter_out, tc, ovf_sticky
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc,
  output logic             ovf_sticky
);
  logic [WIDTH-1:0] step_next;
  logic             step_event;
  logic             fire;
  logic [WIDTH-1:0] clamp_val;
  counter_step #(.WIDTH(WIDTH)) u_step (
    .cur            (counter_out),
    .direction      (direction),
    .max_val        (max_val),
    .sat_mode       (sat_mode),
    .next           (step_next),
    .boundary_event (step_event)
  );
  always_comb begin
    fire      = enable & ~load & step_event;
    clamp_val = load_val > max_val ? max_val : load_val;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_out <= RESET_VAL;
      tc          <= 1'b0;
      ovf_sticky  <= 1'b0;
    end else begin
      counter_out <= load ? clamp_val : enable ? step_next : counter_out;
      tc          <= fire;
      ovf_sticky  <= fire | (ovf_sticky & ~clr_ovf);
    end
  end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed self-checking bench for updown_counter_param
module tb_updown_counter_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       direction = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] max_val = 8'd255;
  logic       sat_mode = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] counter_out;
  logic       tc;
  logic       ovf_sticky;
  int         errors = 0;
  int         checks = 0;
  updown_counter_param #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .direction   (direction),
    .load        (load),
    .load_val    (load_val),
    .max_val     (max_val),
    .sat_mode    (sat_mode),
    .clr_ovf     (clr_ovf),
    .counter_out (counter_out),
    .tc          (tc),
    .ovf_sticky  (ovf_sticky)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect3(input string tag, input int c, input bit t, input bit o);
    check({tag, ".cnt"}, 32'(counter_out), 32'(c));
    check({tag, ".tc"}, 32'(tc), 32'(t));
    check({tag, ".ovf"}, 32'(ovf_sticky), 32'(o));
  endtask
  initial begin
    step();
    step();
    expect3("reset", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect3("hold", 0, 0, 0);
    end
    max_val = 8'd9; direction = 1'b1; sat_mode = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      expect3($sformatf("wrap_up%0d", i), i % 10, i == 10, i >= 10);
    end
    enable = 1'b0; load = 1'b1; load_val = 8'd2; max_val = 8'd200; clr_ovf = 1'b1;
    step();
    expect3("load2_clr", 2, 0, 0);
    load = 1'b0; clr_ovf = 1'b0; direction = 1'b0; sat_mode = 1'b1; enable = 1'b1;
    step(); expect3("sat_dn1", 1, 0, 0);
    step(); expect3("sat_dn0", 0, 0, 0);
    step(); expect3("sat_hold_a", 0, 1, 1);
    step(); expect3("sat_hold_b", 0, 1, 1);
    load = 1'b1; load_val = 8'd250; max_val = 8'd100; direction = 1'b1; sat_mode = 1'b0;
    step(); expect3("load_clamp", 100, 0, 1);
    load = 1'b0;
    step(); expect3("clamp_wrap", 0, 1, 1);
    load = 1'b1; load_val = 8'd37;
    step(); expect3("load37", 37, 0, 1);
    load = 1'b0; rst = 1'b1;
    step(); expect3("rst_mid", 0, 0, 0);
    rst = 1'b0; load = 1'b1; load_val = 8'd50; max_val = 8'd255;
    step(); expect3("load50", 50, 0, 0);
    load = 1'b0; direction = 1'b0; max_val = 8'd20;
    for (int v = 49; v >= 45; v--) begin
      step();
      expect3($sformatf("lowered%0d", v), v, 0, 0);
    end
    direction = 1'b1;
    step(); expect3("lowered_wrap", 0, 1, 1);
    enable = 1'b0;
    step(); expect3("hold_tc0", 0, 0, 1);
    clr_ovf = 1'b1;
    step(); expect3("clr_plain", 0, 0, 0);
    clr_ovf = 1'b0; load = 1'b1; load_val = 8'd254; max_val = 8'd255;
    step(); expect3("load254", 254, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(); expect3("up255", 255, 0, 0);
    clr_ovf = 1'b1;
    step(); expect3("clr_race", 0, 1, 1);
    clr_ovf = 1'b0; max_val = 8'd0; direction = 1'b0; sat_mode = 1'b1;
    step(); expect3("max0_dn", 0, 1, 1);
    direction = 1'b1; sat_mode = 1'b0;
    step(); expect3("max0_up", 0, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
